mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous SRAM between the core's instruction-fetch (IF) and load/store (D) ports.
//   - One transaction outstanding at a time; req/gnt on the request side, rvalid pulse on completion.
//   - Sits between the core pipeline and the unified instruction/data memory of the SoC.
// PARAMETERS
//   ADDR_W   32  byte-address width of all address ports
//   DATA_W   32  data width; byte enables are DATA_W/8 bits
//   MEM_LAT  1   cycles from mem_en to valid mem_rdata; legal range 1..4
// PORTS
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   if_req     in   1         fetch request; held with if_addr until if_gnt
//   if_addr    in   ADDR_W    fetch address
//   if_gnt     out  1         fetch request accepted this cycle
//   if_rvalid  out  1         one-cycle pulse: if_rdata valid
//   if_rdata   out  DATA_W    fetched word; 0 when if_rvalid low
//   d_req      in   1         data request; held with d_* until d_gnt
//   d_we       in   1         1 = write, 0 = read
//   d_be       in   DATA_W/8  byte enables (writes)
//   d_addr     in   ADDR_W    data address
//   d_wdata    in   DATA_W    write data
//   d_gnt      out  1         data request accepted this cycle
//   d_rvalid   out  1         one-cycle pulse: read data valid / write done
//   d_rdata    out  DATA_W    read data; 0 when d_rvalid low or for writes
//   mem_en     out  1         memory access strobe
//   mem_we     out  1         memory write enable
//   mem_be     out  DATA_W/8  memory byte enables
//   mem_addr   out  ADDR_W    memory address
//   mem_wdata  out  DATA_W    memory write data
//   mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//   - Reset (async, rst_n low): state IDLE, counter 0, owner IF.
//     - All outputs are 0 during reset; outstanding transaction is dropped, no rvalid is issued.
//   - FSM IDLE -> BUSY -> IDLE.
//   - IDLE, any req high: grant is combinational in the same cycle.
//     - Exactly one of if_gnt/d_gnt is high; mem_en=1 that cycle.
//     - mem_we/mem_be/mem_addr/mem_wdata are muxed from the winner.
//     - IF grants drive mem_we=0 and mem_be all-ones.
//     - Owner and we are registered; counter loads MEM_LAT; next state BUSY.
//   - IDLE, no req: mem_en=0, mem_* = 0, stay IDLE.
//   - BUSY: no grants, mem_en=0; counter decrements each cycle.
//     - When counter==1, the owner's rvalid is high for one cycle.
//       - Owner read: rdata = mem_rdata. Owner write: rdata = 0.
//     - Next state IDLE.
//   - Grant-to-rvalid latency = MEM_LAT cycles; maximum throughput is one access per MEM_LAT+1 cycles.
//   - Requests that arrive during BUSY wait. A requester may re-raise req in the cycle its rvalid is high; that request is arbitrated in the following IDLE cycle.
//   - Simultaneous if_req and d_req: default fixed priority, D wins and IF waits.
//   - if_rvalid and d_rvalid are never high together; gnt is never high in BUSY.
// CONFIGURATION
//   MEM_PORT_ARB_RR_EN undefined: fixed priority, D over IF. The last-owner register is unused.
//   MEM_PORT_ARB_RR_EN defined: round-robin on conflict.
//     - The requester not granted last wins. last_owner resets to IF, so the first conflict goes to D.
//     - With a single requester, that requester always wins.
// TESTING
//   1. Reset with if_req=1, addr 0x10 -> if_gnt is 0 during reset. First cycle after reset: if_gnt=1, mem_addr=0x10. MEM_LAT cycles later: if_rvalid=1, if_rdata=mem[0x10].
//   2. d_req write 0xDEADBEEF, be=4'b0011, addr 0x20; then read 0x20 -> d_rvalid on each; read data = 0x0000BEEF (memory pre-zeroed).
//   3. if_req and d_req held high for 8 grants.
//      - Without macro: 8 d_gnt, 0 if_gnt.
//      - With MEM_PORT_ARB_RR_EN: D,IF,D,IF,... (4 each).
//   4. Assert rst_n=0 in BUSY after a read grant -> no rvalid is ever issued for that read. After release, state is IDLE and a new request is granted at once.
//   5. MEM_LAT=3, back-to-back d_req -> d_gnt spaced 4 cycles apart; d_rvalid exactly 3 cycles after each gnt; mem_en never high in BUSY.
//   6. Concurrent checker on every test: gnt/rvalid mutually exclusive; rdata=0 whenever its rvalid is low.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// shared single-port SRAM. The arbiter uses the slave view; the core and the
// memory together form the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // SRAM port
    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch (IF) and load/store (D) ports, one access in flight.
// Grants are combinational in IDLE; the owner's rvalid fires MEM_LAT cycles
// later, after which the arbiter returns to IDLE.
// Optional feature: define MEM_PORT_ARB_RR_EN for round-robin on conflict
// (otherwise D has fixed priority over IF).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1   // 1..4
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = 3;

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { OWNER_IF, OWNER_D } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;   // also serves as last owner for round-robin
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick_d;

    // Arbitration, memory mux and completion signalling.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        pick_d        = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = {BE_W{1'b0}};
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = {DATA_W{1'b0}};
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = {DATA_W{1'b0}};

        case (state_q)
            IDLE: begin
                // rst_n gating keeps the combinational grant quiet during reset.
                if (rst_n && (bus.if_req || bus.d_req)) begin
`ifdef MEM_PORT_ARB_RR_EN
                    pick_d = bus.d_req && (!bus.if_req || owner_q == OWNER_IF);
`else
                    pick_d = bus.d_req;
`endif
                    bus.mem_en = 1'b1;
                    cnt_d      = CNT_W'(MEM_LAT);
                    state_d    = BUSY;
                    if (pick_d) begin
                        bus.d_gnt     = 1'b1;
                        bus.mem_we    = bus.d_we;
                        bus.mem_be    = bus.d_be;
                        bus.mem_addr  = bus.d_addr;
                        bus.mem_wdata = bus.d_wdata;
                        owner_d       = OWNER_D;
                        we_d          = bus.d_we;
                    end else begin
                        bus.if_gnt    = 1'b1;
                        bus.mem_be    = {BE_W{1'b1}};
                        bus.mem_addr  = bus.if_addr;
                        owner_d       = OWNER_IF;
                        we_d          = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    if (owner_q == OWNER_D) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = we_q ? {DATA_W{1'b0}} : bus.mem_rdata;
                    end else begin
                        bus.if_rvalid = 1'b1;
                        bus.if_rdata  = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latency counter and owner registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWNER_IF;
            we_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=3). A scheduling model
// (next-free cycle plus a queue of pending completions) predicts grants,
// memory strobes and rvalid/rdata every cycle; directed scenarios cover reset,
// byte-enable writes, conflicts, reset during BUSY and back-to-back spacing.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 3;
`ifdef MEM_PORT_ARB_RR_EN
    localparam int EXP_D3 = 4;
`else
    localparam int EXP_D3 = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- SRAM model: MEM_LAT-deep read pipeline ----------------
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we)
            for (int b = 0; b < BW; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]] : DW'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- requesters ----------------
    bit            rst_v;
    bit            if_pend, d_pend, d_w;
    logic [AW-1:0] if_a, d_a;
    logic [BW-1:0] d_b;
    logic [DW-1:0] d_wd;
    int            p_if = 0, p_d = 0;

    function automatic logic [AW-1:0] rand_addr();
        return AW'({$urandom_range(63), 2'b00});
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            at;
        bit            is_d;
        logic [DW-1:0] data;
    } comp_t;

    comp_t         q[$];
    logic [DW-1:0] ref_mem [64];
    int            cyc = 0, free_at = 0;
    bit            last_d = 1'b0;
    bit            g_if, g_d;

    task automatic model_check();
        bit            win_d, pref_d, e_ifv, e_dv;
        logic [DW-1:0] e_ifd, e_dd;
        logic [BW-1:0] e_be;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit            e_we, idle;
        if (!rst_n) begin
            q.delete();
            last_d  = 1'b0;
            free_at = cyc;
        end
        idle  = (cyc >= free_at);
        g_if  = 1'b0; g_d = 1'b0; win_d = 1'b0;
        e_we  = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
`ifdef MEM_PORT_ARB_RR_EN
        pref_d = !last_d;
`else
        pref_d = 1'b1;
`endif
        if (rst_n && idle && (if_pend || d_pend)) begin
            win_d = d_pend && (!if_pend || pref_d);
            if (win_d) begin
                g_d = 1'b1; e_we = d_w; e_be = d_b; e_addr = d_a; e_wd = d_wd;
            end else begin
                g_if = 1'b1; e_be = '1; e_addr = if_a;
            end
        end
        e_ifv = 1'b0; e_dv = 1'b0; e_ifd = '0; e_dd = '0;
        if (q.size() > 0 && q[0].at == cyc) begin
            if (q[0].is_d) begin e_dv = 1'b1; e_dd = q[0].data; end
            else begin e_ifv = 1'b1; e_ifd = q[0].data; end
        end

        check("if_gnt",    64'(bus.if_gnt),    64'(g_if));
        check("d_gnt",     64'(bus.d_gnt),     64'(g_d));
        check("mem_en",    64'(bus.mem_en),    64'(g_if | g_d));
        if (g_if || g_d || !rst_n || idle) begin
            check("mem_we",   64'(bus.mem_we),   64'(e_we));
            check("mem_be",   64'(bus.mem_be),   64'(e_be));
            check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
        end
        if (g_d || !rst_n || (idle && !g_if))
            check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wd));
        check("if_rvalid", 64'(bus.if_rvalid), 64'(e_ifv));
        check("if_rdata",  64'(bus.if_rdata),  64'(e_ifd));
        check("d_rvalid",  64'(bus.d_rvalid),  64'(e_dv));
        check("d_rdata",   64'(bus.d_rdata),   64'(e_dd));
        // Structural invariants, independent of the model's timing.
        check("gnt_excl",  64'(bus.if_gnt & bus.d_gnt),       64'(0));
        check("rv_excl",   64'(bus.if_rvalid & bus.d_rvalid), 64'(0));
        check("if_rd_zero", 64'(bus.if_rvalid ? '0 : bus.if_rdata), 64'(0));
        check("d_rd_zero",  64'(bus.d_rvalid  ? '0 : bus.d_rdata),  64'(0));

        if (q.size() > 0 && q[0].at == cyc) void'(q.pop_front());
        if (g_if || g_d) begin
            comp_t c;
            c.at   = cyc + LAT;
            c.is_d = win_d;
            c.data = (win_d && d_w) ? '0 : ref_mem[e_addr[7:2]];
            if (win_d && d_w)
                for (int b = 0; b < BW; b++)
                    if (d_b[b]) ref_mem[d_a[7:2]][8*b +: 8] = d_wd[8*b +: 8];
            q.push_back(c);
            free_at = cyc + LAT + 1;
            last_d  = win_d;
        end
        if (g_if) if_pend = 1'b0;
        if (g_d)  d_pend  = 1'b0;
        cyc++;
    endtask

    // One clock: drive inputs just after the edge, check at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (!if_pend && $urandom_range(99) < p_if) begin
            if_pend = 1'b1;
            if_a    = rand_addr();
        end
        if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend = 1'b1;
            d_w    = 1'($urandom_range(1));
            d_b    = BW'($urandom);
            d_a    = rand_addr();
            d_wd   = DW'($urandom);
        end
        rst_n       = rst_v;
        bus.if_req  = if_pend;
        bus.if_addr = if_a;
        bus.d_req   = d_pend;
        bus.d_we    = d_w;
        bus.d_be    = d_b;
        bus.d_addr  = d_a;
        bus.d_wdata = d_wd;
        @(negedge clk);
        model_check();
    endtask

    task automatic issue_d(input bit we, input logic [BW-1:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input string tag, output logic [DW-1:0] rd);
        int n = 0;
        d_pend = 1'b1; d_w = we; d_b = be; d_a = a; d_wd = wd;
        do begin
            step();
            n++;
        end while (!g_d && n < 20);
        if (!g_d) check({tag, "_gnt_timeout"}, 64'(0), 64'(1));
        repeat (LAT) step();
        check({tag, "_rvalid"}, 64'(bus.d_rvalid), 64'(1));
        rd = bus.d_rdata;
    endtask

    task automatic drain();
        int n = 0;
        p_if = 0; p_d = 0;
        while ((if_pend || d_pend || q.size() > 0 || cyc < free_at) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        logic [DW-1:0] rd;
        int dc, ic, n, ng, last_g, rv_seen;

        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        d_w = 1'b0; d_b = '0; d_a = '0; d_wd = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            mem[i]    <= '0;
        end
        ref_mem[4] = 32'h1234_5678;
        mem[4]    <= 32'h1234_5678;
        for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;

        // 1: fetch held through reset, granted on the first cycle after release.
        rst_v = 1'b0; if_pend = 1'b1; if_a = 32'h10; d_pend = 1'b0;
        repeat (3) begin
            step();
            check("t1_rst_if_gnt", 64'(bus.if_gnt), 64'(0));
            check("t1_rst_mem_en", 64'(bus.mem_en), 64'(0));
        end
        rst_v = 1'b1;
        step();
        check("t1_if_gnt",   64'(bus.if_gnt),   64'(1));
        check("t1_mem_addr", 64'(bus.mem_addr), 64'(32'h10));
        repeat (LAT) step();
        check("t1_if_rvalid", 64'(bus.if_rvalid), 64'(1));
        check("t1_if_rdata",  64'(bus.if_rdata),  64'(32'h1234_5678));

        // 2: partial write then read back.
        issue_d(1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, "t2w", rd);
        check("t2_wr_rdata", 64'(rd), 64'(0));
        issue_d(1'b0, 4'b1111, 32'h20, 32'h0, "t2r", rd);
        check("t2_rd_rdata", 64'(rd), 64'(32'h0000_BEEF));

        // 3: both ports requesting continuously for 8 grants.
        p_if = 100; p_d = 100; dc = 0; ic = 0; n = 0;
        while (dc + ic < 8 && n < 100) begin
            step();
            if (bus.d_gnt)  dc++;
            if (bus.if_gnt) ic++;
            n++;
        end
        check("t3_d_gnts",  64'(dc), 64'(EXP_D3));
        check("t3_if_gnts", 64'(ic), 64'(8 - EXP_D3));
        drain();

        // 4: reset while a read is in flight; no rvalid, then immediate grant.
        d_pend = 1'b1; d_w = 1'b0; d_b = '1; d_a = 32'h10; d_wd = '0;
        n = 0;
        do begin step(); n++; end while (!g_d && n < 20);
        step();
        rv_seen = 0;
        rst_v = 1'b0;
        step();
        rv_seen += int'(bus.d_rvalid) + int'(bus.if_rvalid);
        d_pend = 1'b1; d_w = 1'b0; d_b = '1; d_a = 32'h20;
        step();
        rv_seen += int'(bus.d_rvalid) + int'(bus.if_rvalid);
        rst_v = 1'b1;
        step();
        check("t4_no_rvalid", 64'(rv_seen), 64'(0));
        check("t4_d_gnt",     64'(bus.d_gnt), 64'(1));
        drain();

        // 5: back-to-back data requests, spaced MEM_LAT+1 cycles.
        p_d = 100; ng = 0; last_g = -1; n = 0;
        while (ng < 5 && n < 60) begin
            step();
            if (bus.d_gnt) begin
                if (last_g >= 0) check("t5_gap", 64'(n - last_g), 64'(LAT + 1));
                last_g = n;
                ng++;
            end
            n++;
        end
        if (ng < 5) check("t5_timeout", 64'(0), 64'(1));
        drain();

        // Randomized traffic at moderate and heavy load.
        p_if = 40; p_d = 40;
        repeat (800) step();
        p_if = 85; p_d = 85;
        repeat (400) step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
